// File: rtl/tr_pwm_pkg.sv
// Shared constants, FSM state type and edge arithmetic for the per-transducer
// pulse generator. The period is 2**CNT_W ticks and CNT_W must be DATA_W+1.
package tr_pwm_pkg;

  localparam int CNT_W  = 9;
  localparam int DATA_W = 8;
  localparam int PERIOD = 1 << CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] rise;
    logic [CNT_W-1:0] fall;
  } edges_t;

  // Center sits at 2*phase; duty is zero-extended so the width is 2*duty ticks.
  function automatic edges_t edge_calc(input logic [DATA_W-1:0] duty,
                                       input logic [DATA_W-1:0] phase);
    edges_t           e;
    logic [CNT_W-1:0] center;
    logic [CNT_W-1:0] half;
    center = {phase, 1'b0};
    half   = {1'b0, duty};
    e.rise = center - half;
    e.fall = center + half;
    return e;
  endfunction

endpackage

// File: rtl/tr_pwm_if.sv
// Duty/phase stream and period-counter bundle feeding one pulse generator,
// plus its drive and armed outputs.
interface tr_pwm_if;
  import tr_pwm_pkg::*;

  logic [CNT_W-1:0]  time_cnt;
  logic              update;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] phase;
  logic              pwm_out;
  logic              armed;

  modport master (
    output time_cnt, update, duty, phase,
    input  pwm_out, armed
  );

  modport slave (
    input  time_cnt, update, duty, phase,
    output pwm_out, armed
  );

endinterface

// File: rtl/tr_pwm_slew.sv
// Rate limiter for duty/phase: each UPDATE moves the held values one step toward
// the targets (phase along the shorter circular path). Used with TR_PWM_SLEW_EN.
module tr_pwm_slew
  import tr_pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              update_i,
  input  logic [DATA_W-1:0] duty_i,
  input  logic [DATA_W-1:0] phase_i,
  output logic [DATA_W-1:0] duty_nxt_o,
  output logic [DATA_W-1:0] phase_nxt_o
);

  logic [DATA_W-1:0] duty_cur_q, duty_cur_d;
  logic [DATA_W-1:0] phase_cur_q, phase_cur_d;
  logic [DATA_W-1:0] phase_diff;

  always_comb begin
    duty_cur_d  = duty_cur_q;
    phase_cur_d = phase_cur_q;
    phase_diff  = phase_i - phase_cur_q;
    if (duty_i > duty_cur_q) begin
      duty_cur_d = duty_cur_q + 1'b1;
    end else if (duty_i < duty_cur_q) begin
      duty_cur_d = duty_cur_q - 1'b1;
    end
    // Upper half of the modular difference means going backwards is shorter.
    if (phase_diff != '0) begin
      phase_cur_d = phase_diff[DATA_W-1] ? phase_cur_q - 1'b1 : phase_cur_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      duty_cur_q  <= '0;
      phase_cur_q <= '0;
    end else if (update_i) begin
      duty_cur_q  <= duty_cur_d;
      phase_cur_q <= phase_cur_d;
    end
  end

  assign duty_nxt_o  = duty_cur_d;
  assign phase_nxt_o = phase_cur_d;

endmodule

// File: rtl/tr_pwm_gen.sv
// Center-aligned drive pulse generator for one transducer. Define TR_PWM_SLEW_EN
// to rate-limit duty/phase changes through tr_pwm_slew.
module tr_pwm_gen
  import tr_pwm_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  tr_pwm_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rise_q, fall_q;
  logic             pwm_q, pwm_d;
  logic             in_win;
  edges_t           edges_d;

`ifdef TR_PWM_SLEW_EN
  logic [DATA_W-1:0] duty_nxt;
  logic [DATA_W-1:0] phase_nxt;

  tr_pwm_slew u_slew (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .update_i    (bus.update),
    .duty_i      (bus.duty),
    .phase_i     (bus.phase),
    .duty_nxt_o  (duty_nxt),
    .phase_nxt_o (phase_nxt)
  );

  assign edges_d = edge_calc(duty_nxt, phase_nxt);
`else
  assign edges_d = edge_calc(bus.duty, bus.phase);
`endif

  // Equal edges only happen at zero duty, which must stay dark.
  always_comb begin
    in_win = 1'b0;
    if (rise_q < fall_q) begin
      in_win = (bus.time_cnt >= rise_q) && (bus.time_cnt < fall_q);
    end else if (rise_q > fall_q) begin
      in_win = (bus.time_cnt >= rise_q) || (bus.time_cnt < fall_q);
    end
  end

  always_comb begin
    state_d = state_q;
    pwm_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.update) state_d = ARM;
      ARM:  state_d = RUN;
      RUN:  pwm_d = in_win;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pwm_q   <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      if (bus.update) begin
        rise_q <= edges_d.rise;
        fall_q <= edges_d.fall;
      end
    end
  end

  assign bus.pwm_out = pwm_q;
  assign bus.armed   = (state_q != IDLE);

endmodule

// File: tb/tb_tr_pwm_gen.sv
// Bench for tr_pwm_gen: drives the shared period counter and random duty/phase
// traffic, comparing against a behavioural pulse model.
module tb_tr_pwm_gen;
  import tr_pwm_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tr_pwm_if bus ();

  tr_pwm_gen dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: cycles since arming (-1 = not armed) and the active duty/phase.
  int m_cyc   = -1;
  int m_duty  = 0;
  int m_phase = 0;
  int s_duty  = 0;
  int s_phase = 0;

  // Pulse of width 2*d centred on tick 2*p, measured circularly.
  function automatic bit win(int t, int d, int p);
    int w;
    w = (t - (2 * p - d)) % PERIOD;
    if (w < 0) w += PERIOD;
    return w < 2 * d;
  endfunction

  task automatic step(output logic ep, output logic ea);
    int t;
    int diff;
    t = int'(bus.time_cnt);
    if (!rst_n) begin
      m_cyc = -1; m_duty = 0; m_phase = 0; s_duty = 0; s_phase = 0;
      ep = 1'b0;
    end else begin
      ep = (m_cyc >= 1) && win(t, m_duty, m_phase);
      if (bus.update) begin
`ifdef TR_PWM_SLEW_EN
        if (int'(bus.duty) > s_duty) s_duty++;
        else if (int'(bus.duty) < s_duty) s_duty--;
        diff = (int'(bus.phase) - s_phase + 256) % 256;
        if (diff >= 1 && diff <= 127) s_phase = (s_phase + 1) % 256;
        else if (diff != 0) s_phase = (s_phase + 255) % 256;
        m_duty  = s_duty;
        m_phase = s_phase;
`else
        diff    = 0;
        m_duty  = int'(bus.duty);
        m_phase = int'(bus.phase) + diff;
`endif
        m_cyc = (m_cyc < 0) ? 0 : m_cyc + 1;
      end else if (m_cyc >= 0) begin
        m_cyc++;
      end
      if (m_cyc > 2) m_cyc = 2;
    end
    ea = (m_cyc >= 0);
    @(posedge clk);
    #1;
    bus.time_cnt = 9'(bus.time_cnt + 9'd1);
    bus.update   = (bus.time_cnt == 9'(PERIOD - 1));
  endtask

  // Advances n cycles, counting model disagreements and collecting pulse stats
  // (rise/fall reported as the sampled TIME_CNT that produced the transition).
  task automatic run_steps(input int n, output int highs, output int rise_t,
                           output int fall_t, output int bad);
    logic ep, ea, prev;
    int   tprev;
    highs = 0; rise_t = -1; fall_t = -1; bad = 0;
    prev  = bus.pwm_out;
    for (int i = 0; i < n; i++) begin
      tprev = int'(bus.time_cnt);
      step(ep, ea);
      if (bus.pwm_out !== ep || bus.armed !== ea) bad++;
      if (bus.pwm_out === 1'b1) highs++;
      if (bus.pwm_out === 1'b1 && prev === 1'b0 && rise_t < 0) rise_t = tprev;
      if (bus.pwm_out === 1'b0 && prev === 1'b1 && fall_t < 0) fall_t = tprev;
      prev = bus.pwm_out;
    end
  endtask

  task automatic test_reset();
    logic ep, ea;
    rst_n = 1'b0;
    repeat (3) begin
      step(ep, ea);
      checks++;
      if (bus.pwm_out !== 1'b0 || bus.armed !== 1'b0) begin
        errors++;
        $display("FAIL reset_out pwm=%b armed=%b want 0/0", bus.pwm_out, bus.armed);
      end
    end
    rst_n = 1'b1;
    while (bus.time_cnt != 9'(PERIOD - 1)) begin
      bus.duty  = 8'($urandom);
      bus.phase = 8'($urandom);
      step(ep, ea);
      checks++;
      if (bus.pwm_out !== 1'b0 || bus.armed !== 1'b0) begin
        errors++;
        $display("FAIL pre_update t=%0d pwm=%b armed=%b want 0/0",
                 bus.time_cnt, bus.pwm_out, bus.armed);
      end
    end
  endtask

`ifdef TR_PWM_SLEW_EN
  task automatic test_slew();
    int h, r, f, b;
    int want_d, want_p;
    bus.duty  = 8'h05;
    bus.phase = 8'hFE;
    for (int k = 1; k <= 7; k++) begin
      run_steps(1, h, r, f, b);
      want_d = (k < 5) ? k : 5;
      want_p = (k == 1) ? 8'hFF : 8'hFE;
      checks++;
      if (int'(dut.u_slew.duty_cur_q) !== want_d || int'(dut.u_slew.phase_cur_q) !== want_p) begin
        errors++;
        $display("FAIL slew_step k=%0d duty=%0d phase=%0h want %0d/%0h", k,
                 dut.u_slew.duty_cur_q, dut.u_slew.phase_cur_q, want_d, want_p);
      end
      run_steps(PERIOD - 1, h, r, f, b);
      checks++;
      if (b != 0) begin errors++; $display("FAIL slew_wave k=%0d bad=%0d want 0", k, b); end
    end
  endtask
`endif

  task automatic test_center();
    int h, r, f, b;
    bus.duty  = 8'h80;
    bus.phase = 8'h80;
    run_steps(1, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0) begin errors++; $display("FAIL center_model bad=%0d want 0", b); end
`ifndef TR_PWM_SLEW_EN
    checks++;
    if (h != 256 || r != 128 || f != 384) begin
      errors++;
      $display("FAIL center_p1 highs=%0d rise=%0d fall=%0d want 256/128/384", h, r, f);
    end
`endif
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0) begin errors++; $display("FAIL center_repeat bad=%0d want 0", b); end
`ifndef TR_PWM_SLEW_EN
    checks++;
    if (h != 256 || r != 128 || f != 384) begin
      errors++;
      $display("FAIL center_p2 highs=%0d rise=%0d fall=%0d want 256/128/384", h, r, f);
    end
`endif
  endtask

  task automatic test_wrap();
    int h, r, f, b;
    bus.duty  = 8'h40;
    bus.phase = 8'h00;
    run_steps(PERIOD, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0) begin errors++; $display("FAIL wrap_model bad=%0d want 0", b); end
`ifndef TR_PWM_SLEW_EN
    checks++;
    if (h != 128 || f != 64) begin
      errors++;
      $display("FAIL wrap_p1 highs=%0d fall=%0d want 128/64", h, f);
    end
`endif
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN (h != 128 || r != 448 || f != 64) `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL wrap_p2 bad=%0d highs=%0d rise=%0d fall=%0d want 0/128/448/64", b, h, r, f);
    end
  endtask

  task automatic test_zero_full();
    int h, r, f, b;
    bus.duty  = 8'h00;
    bus.phase = 8'($urandom);
    run_steps(PERIOD, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN h != 0 `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL zero_duty bad=%0d highs=%0d want 0/0", b, h);
    end
    bus.duty  = 8'hFF;
    bus.phase = 8'h80;
    run_steps(PERIOD, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN (h != 510 || r != 1 || f != 511) `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL full_duty bad=%0d highs=%0d rise=%0d fall=%0d want 0/510/1/511", b, h, r, f);
    end
  endtask

  task automatic test_hold();
    int h, r, f, b;
    run_steps(200, h, r, f, b);
    bus.duty  = 8'h10;
    bus.phase = 8'h40;
    run_steps(PERIOD - 201, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN h != 311 `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL hold_no_update bad=%0d highs=%0d want 0/311", b, h);
    end
    run_steps(1, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN (h != 32 || r != 112 || f != 144) `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL hold_after_update bad=%0d highs=%0d rise=%0d fall=%0d want 0/32/112/144",
               b, h, r, f);
    end
  endtask

  task automatic test_random();
    int h, r, f, b, k;
    for (int p = 0; p < 6; p++) begin
      bus.duty  = 8'($urandom);
      bus.phase = 8'($urandom);
      k = $urandom_range(1, PERIOD - 2);
      run_steps(k, h, r, f, b);
      checks++;
      if (b != 0) begin errors++; $display("FAIL random_a p=%0d bad=%0d want 0", p, b); end
      bus.duty  = 8'($urandom);
      bus.phase = 8'($urandom);
      run_steps(PERIOD - k, h, r, f, b);
      checks++;
      if (b != 0) begin errors++; $display("FAIL random_b p=%0d bad=%0d want 0", p, b); end
    end
  endtask

  task automatic test_reset_mid();
    int h, r, f, b;
    bus.duty  = 8'h80;
    bus.phase = 8'h80;
    run_steps(PERIOD, h, r, f, b);
    run_steps(PERIOD, h, r, f, b);
    run_steps(200, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN bus.pwm_out !== 1'b1 `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL mid_pre bad=%0d pwm=%b want 0/1", b, bus.pwm_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pwm_out !== 1'b0 || bus.armed !== 1'b0) begin
      errors++;
      $display("FAIL mid_async pwm=%b armed=%b want 0/0", bus.pwm_out, bus.armed);
    end
    run_steps(3, h, r, f, b);
    rst_n = 1'b1;
    run_steps(PERIOD - int'(bus.time_cnt), h, r, f, b);
    checks++;
    if (b != 0 || h != 0) begin
      errors++;
      $display("FAIL mid_rearm_wait bad=%0d highs=%0d want 0/0", b, h);
    end
    run_steps(PERIOD, h, r, f, b);
    checks++;
    if (b != 0 || (`ifndef TR_PWM_SLEW_EN h != 256 `else 1'b0 `endif)) begin
      errors++;
      $display("FAIL mid_rearm bad=%0d highs=%0d want 0/256", b, h);
    end
  endtask

  initial begin
    bus.time_cnt = 9'd500;
    bus.update   = 1'b0;
    bus.duty     = 8'($urandom);
    bus.phase    = 8'($urandom);
    test_reset();
`ifdef TR_PWM_SLEW_EN
    test_slew();
`endif
    test_center();
    test_wrap();
    test_zero_full();
    test_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tr_pwm_gen.md
Name: tr_pwm_gen

Overview:
- Per-transducer drive-pulse generator; it is the consumer end of the delayed duty/phase stream (the delay-FIFO output).
- Latches {DUTY, PHASE} on the per-period UPDATE strobe and converts them to a center-aligned pulse against the shared 512-tick ultrasound counter.
- One instance per transducer; PWM_OUT feeds the transducer driver pin.

Parameters:
- CNT_W, 9, width of TIME_CNT; period = 2**CNT_W ticks; must equal DATA_W+1.
- DATA_W, 8, width of DUTY and PHASE.

Ports:
- CLK  in  1  system clock (ultrasound counter clock).
- RST_N  in  1  asynchronous, active-low reset.
- TIME_CNT  in  CNT_W  shared period counter, 0..511, increments every CLK.
- UPDATE  in  1  one-cycle strobe, high while TIME_CNT==511.
- DUTY  in  DATA_W  pulse half-width target.
- PHASE  in  DATA_W  pulse center target, in units of 2 ticks.
- PWM_OUT  out  1  registered drive output.
- ARMED  out  1  high once the first UPDATE has been consumed.

Behaviour:
- Reset (async assert): PWM_OUT=0, ARMED=0, state=IDLE, rise/fall/duty_cur/phase_cur=0. Deassertion is synchronous to CLK; the driving logic handles that.
- Edge computation, all mod 2**CNT_W, CNT_W bits:
  - rise = 2*PHASE − DUTY
  - fall = 2*PHASE + DUTY
  - DUTY is zero-extended, so the pulse width is 2*DUTY ticks (0..510).
- Active window:
  - rise<fall: high when rise ≤ t < fall.
  - rise>fall (wrap): high when t ≥ rise or t < fall.
  - rise==fall (DUTY==0): never high.
- Load: at the CLK edge where UPDATE=1, rise/fall are registered from the current inputs. They are effective from TIME_CNT==0 of the next period. DUTY/PHASE changes without UPDATE have no effect.
- Output latency: PWM_OUT at the edge after the cycle with TIME_CNT=t reflects the window test of t (1 cycle).
- FSM:
  - IDLE: PWM_OUT forced 0; UPDATE → ARM (edges loaded).
  - ARM: PWM_OUT 0 for one cycle (TIME_CNT==0 in the sampled cycle) → RUN; ARMED=1 from entry to ARM.
  - RUN: window test active; later UPDATEs reload edges and stay in RUN.
  - No exit except reset.
- UPDATE while TIME_CNT≠511 is still honoured (the loaded edges apply immediately from the next cycle). The bench does not generate it; no error flag.
- Reset mid-pulse: PWM_OUT drops to 0 asynchronously; the block returns to IDLE and needs a fresh UPDATE.

Optional Feature:
- Macro: TR_PWM_SLEW_EN.
- With it: edges are computed from internal duty_cur/phase_cur, not the inputs. On each UPDATE:
  - duty_cur steps ±1 toward DUTY (saturating, no overshoot).
  - phase_cur steps ±1 toward PHASE along the shorter circular path. With d=(PHASE−phase_cur) mod 256: d in 1..127 → +1; d in 128..255 → −1 (mod 256); d==0 → hold.
  - Edges use the post-step values, loaded at the same UPDATE edge.
  - First UPDATE after reset steps from 0/0.
- Without it: duty_cur/phase_cur do not exist; edges come directly from the inputs.

Decomposition:
- Package tr_pwm_pkg: CNT_W/DATA_W constants, period constant, state enum {IDLE, ARM, RUN}, and an edge-calc function returning {rise, fall}.
- Sub-module tr_pwm_slew holds the slew registers and is instantiated only under TR_PWM_SLEW_EN.
- Window comparator and FSM stay in tr_pwm_gen.

Test Plan:
- DUTY=0x80, PHASE=0x80, one UPDATE → from the next period, PWM_OUT high exactly 256 cycles, rising 1 cycle after TIME_CNT==128 and falling 1 cycle after TIME_CNT==384; repeats every 512.
- DUTY=0x40, PHASE=0x00 → wrap window TIME_CNT 448..511 and 0..63; PWM_OUT high 128 contiguous cycles across the period boundary.
- DUTY=0x00 with any PHASE → PWM_OUT constantly 0. DUTY=0xFF, PHASE=0x80 → high for TIME_CNT 1..510 (510 cycles).
- Change DUTY/PHASE at TIME_CNT=200 with no UPDATE → waveform unchanged until after the next UPDATE; before the first UPDATE after reset, PWM_OUT=0 and ARMED=0.
- Assert RST_N=0 while PWM_OUT=1 → PWM_OUT=0 within the same cycle (async); after release, PWM_OUT stays 0 until an UPDATE plus a new period.
- With TR_PWM_SLEW_EN: target DUTY=0x05, PHASE=0xFE from reset → duty_cur 1,2,…,5 over 5 UPDATEs; phase_cur 0→0xFF→0xFE (decrementing path); steady thereafter.
